// File: rtl/rr_mem_rd_arbiter.sv
// rr_mem_rd_arbiter: round-robin share of the packet-buffer read port with fixed-latency data return.
// Define RD_ARB_BURST_EN to add locked bursts (mem_last_i, MAX_BURST).
package mem_pkg;
  localparam int ADDR_W     = 10;
  localparam int BLOCK_BITS = 64;
endpackage

module rr_mem_rd_arbiter
  import mem_pkg::*;
#(
  parameter int N         = 4,
  parameter int RD_LAT    = 2,
  parameter int MAX_BURST = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N-1:0]               mem_re_i,
  input  logic [N-1:0][ADDR_W-1:0]   mem_addr_i,
  output logic [N-1:0]               mem_gnt_o,
  output logic [N-1:0]               mem_rvalid_o,
  output logic [BLOCK_BITS-1:0]      mem_rdata_o,
  output logic                       mem_re_o,
  output logic [ADDR_W-1:0]          mem_addr_o,
  input  logic [BLOCK_BITS-1:0]      mem_rdata_i
`ifdef RD_ARB_BURST_EN
  ,
  input  logic [N-1:0]               mem_last_i
`endif
);
  localparam int PW = $clog2(N);

  if (N < 2 || N > 16 || RD_LAT < 1 || RD_LAT > 8 || MAX_BURST < 1 || MAX_BURST > 64)
    $error("rr_mem_rd_arbiter: parameter out of range");

  logic [PW-1:0]             r_ptr, w_ptr_nxt, w_rr_win, w_win;
  logic                      w_rr_hit, w_hit;
  logic [RD_LAT-1:0]         r_pv;
  logic [RD_LAT-1:0][PW-1:0] r_pid;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] v);
    return (v == PW'(N - 1)) ? '0 : v + 1'b1;
  endfunction

  // first requester at or after the pointer, wrapping around
  always_comb begin
    w_rr_hit = 1'b0;
    w_rr_win = '0;
    for (int k = 0; k < N; k++)
      if (!w_rr_hit && mem_re_i[(int'(r_ptr) + k) % N]) begin
        w_rr_hit = 1'b1;
        w_rr_win = PW'((int'(r_ptr) + k) % N);
      end
  end

`ifdef RD_ARB_BURST_EN
  typedef enum logic {S_IDLE, S_LOCKED} state_t;
  localparam int BW = $clog2(MAX_BURST + 1);

  state_t        r_state, w_state_nxt;
  logic [PW-1:0] r_owner, w_owner_nxt;
  logic [BW-1:0] r_beats, w_beats_nxt;
  logic          w_end;

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_beats <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_beats <= w_beats_nxt;
    end

  always_comb begin
    w_hit = (r_state == S_LOCKED) ? mem_re_i[r_owner] : w_rr_hit;
    w_win = (r_state == S_LOCKED) ? r_owner : w_rr_win;
  end

  assign w_end = mem_last_i[r_owner] || (r_beats + 1'b1 == BW'(MAX_BURST));

  // the pointer only moves when a burst (or a single-beat grant) completes
  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_beats_nxt = r_beats;
    w_ptr_nxt   = r_ptr;
    if (r_state == S_IDLE) begin
      if (w_hit && !mem_last_i[w_win] && MAX_BURST > 1) begin
        w_state_nxt = S_LOCKED;
        w_owner_nxt = w_win;
        w_beats_nxt = BW'(1);
      end else if (w_hit)
        w_ptr_nxt = inc(w_win);
    end else if (w_hit) begin
      if (w_end) begin
        w_state_nxt = S_IDLE;
        w_beats_nxt = '0;
        w_ptr_nxt   = inc(r_owner);
      end else
        w_beats_nxt = r_beats + 1'b1;
    end
  end
`else
  always_comb begin
    w_hit     = w_rr_hit;
    w_win     = w_rr_win;
    w_ptr_nxt = w_rr_hit ? inc(w_rr_win) : r_ptr;
  end
`endif

  always_ff @(posedge clk)
    if (!rst_n) begin
      r_ptr <= '0;
      r_pv  <= '0;
      r_pid <= '0;
    end else begin
      r_ptr    <= w_ptr_nxt;
      r_pv[0]  <= w_hit;
      r_pid[0] <= w_win;
      for (int s = 1; s < RD_LAT; s++) begin
        r_pv[s]  <= r_pv[s-1];
        r_pid[s] <= r_pid[s-1];
      end
    end

  assign mem_gnt_o    = w_hit ? (N'(1) << w_win) : '0;
  assign mem_re_o     = w_hit;
  assign mem_addr_o   = w_hit ? mem_addr_i[w_win] : '0;
  assign mem_rvalid_o = r_pv[RD_LAT-1] ? (N'(1) << r_pid[RD_LAT-1]) : '0;
  assign mem_rdata_o  = mem_rdata_i;
endmodule

// File: tb/tb_rr_mem_rd_arbiter.sv
// tb_rr_mem_rd_arbiter: directed checks of grant order, address mux, return routing and reset flush.
module tb_rr_mem_rd_arbiter;
  import mem_pkg::*;
  localparam int N = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic [N-1:0]             mem_re_i = '0;
  logic [N-1:0][ADDR_W-1:0] mem_addr_i = '0;
  logic [N-1:0]             mem_gnt_o, mem_rvalid_o;
  logic [BLOCK_BITS-1:0]    mem_rdata_o, mem_rdata_i;
  logic                     mem_re_o;
  logic [ADDR_W-1:0]        mem_addr_o;
`ifdef RD_ARB_BURST_EN
  logic [N-1:0]             mem_last_i = '1;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0]      e_g[2];
  logic [ADDR_W-1:0] e_a[2];
  logic              m_v[2];
  logic [ADDR_W-1:0] m_a[2];

  rr_mem_rd_arbiter #(.N(N), .RD_LAT(2), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .mem_re_i(mem_re_i), .mem_addr_i(mem_addr_i),
    .mem_gnt_o(mem_gnt_o), .mem_rvalid_o(mem_rvalid_o), .mem_rdata_o(mem_rdata_o),
    .mem_re_o(mem_re_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i)
`ifdef RD_ARB_BURST_EN
    , .mem_last_i(mem_last_i)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [BLOCK_BITS-1:0] mdata(input logic [ADDR_W-1:0] a);
    return BLOCK_BITS'(64'hC0DE_0000_0000_0000 | (64'(a) * 64'h0000_0001_0001));
  endfunction

  // memory with a two-cycle read latency
  always @(posedge clk) begin
    m_v[0] <= mem_re_o;
    m_a[0] <= mem_addr_o;
    m_v[1] <= m_v[0];
    m_a[1] <= m_a[0];
  end
  assign mem_rdata_i = m_v[1] ? mdata(m_a[1]) : '0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [N-1:0] re, input logic [N-1:0] g,
                     input logic do_g = 1'b1);
    logic [ADDR_W-1:0] a;
    mem_re_i = re;
    #3;
    a = '0;
    for (int i = 0; i < N; i++) if (g[i]) a = mem_addr_i[i];
    if (do_g) begin
      chk({tag, " gnt"}, 64'(mem_gnt_o), 64'(g));
      chk({tag, " re"}, 64'(mem_re_o), 64'(|g));
      chk({tag, " addr"}, 64'(mem_addr_o), 64'(a));
    end
    chk({tag, " rvalid"}, 64'(mem_rvalid_o), 64'(e_g[1]));
    if (|e_g[1]) chk({tag, " rdata"}, 64'(mem_rdata_o), 64'(mdata(e_a[1])));
    @(posedge clk);
    if (!rst_n) begin
      e_g[0] = '0;
      e_g[1] = '0;
    end else begin
      e_g[1] = e_g[0];
      e_a[1] = e_a[0];
      e_g[0] = g;
      e_a[0] = a;
    end
    #1;
  endtask

  initial begin
    e_g[0] = '0; e_g[1] = '0; e_a[0] = '0; e_a[1] = '0;
    mem_addr_i = {10'h103, 10'h102, 10'h101, 10'h100};
    repeat (2) @(posedge clk);
    #1;
    cyc("reset", '0, '0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) cyc("all_req", 4'hF, 4'b0001 << (i % 4));
    repeat (2) cyc("drain", '0, '0);
    mem_addr_i[2] = 10'h01A;
    cyc("p2_only", 4'b0100, 4'b0100);
    repeat (2) cyc("p2_ret", '0, '0);
    cyc("ptr_is_3", 4'b1001, 4'b1000);
    cyc("wrap_p0", 4'b1001, 4'b0001);
    cyc("wrap_p3", 4'b1000, 4'b1000);
    cyc("p1_only", 4'b0010, 4'b0010);
    repeat (5) cyc("idle", '0, '0);
    cyc("after_idle", 4'hF, 4'b0100);
    rst_n = 1'b0;
    cyc("rst_mid", 4'hF, 4'b1000, 1'b0);
    rst_n = 1'b1;
    repeat (2) cyc("post_rst", '0, '0);
    cyc("ptr_is_0", 4'hF, 4'b0001);
    repeat (2) cyc("drain2", '0, '0);
`ifdef RD_ARB_BURST_EN
    rst_n = 1'b0;
    cyc("b_rst", '0, '0);
    rst_n = 1'b1;
    mem_last_i = '0;
    for (int i = 0; i < 4; i++) cyc("burst_max", 4'b0110, 4'b0010);
    cyc("burst_rel", 4'b0110, 4'b0100);
    rst_n = 1'b0;
    cyc("b_rst2", '0, '0);
    rst_n = 1'b1;
    cyc("burst_l1", 4'b0110, 4'b0010);
    mem_last_i = 4'b0010;
    cyc("burst_l2", 4'b0110, 4'b0010);
    mem_last_i = '0;
    cyc("burst_last_rel", 4'b0110, 4'b0100);
    mem_last_i = '1;
    repeat (2) cyc("b_drain", '0, '0);
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
